// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS datapath (no forwarding): RAW scoreboard, ID redirects, EX jr.
// Optional build macro WB_BYPASS_EN: write-before-read register file, so the WB slot is not hazard-checked.

module pipeline_hazard_ctrl_slot #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      vld_i,
  input  logic [REG_ADDR_WIDTH-1:0] dst_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_i,
  input  logic                      use_rs_i,
  input  logic                      use_rt_i,
  output logic                      hit_o
);
  assign hit_o = vld_i & (dst_i != '0) &
                 ((use_rs_i & (dst_i == rs_i)) | (use_rt_i & (dst_i == rt_i)));
endmodule

module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SB_DEPTH       = 3,
  parameter int JR_PENALTY     = 2,
  parameter int MAX_STALL      = 7,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_use_rs,
  input  logic                      id_use_rt,
  input  logic                      id_regWrite,
  input  logic [REG_ADDR_WIDTH-1:0] id_regToWrite,
  input  logic                      id_redirect,
  input  logic                      ex_jr,
  output logic                      pc_en_n,
  output logic                      ifid_en_n,
  output logic                      if_flush,
  output logic                      idex_bubble,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic                      err
);
`ifdef WB_BYPASS_EN
  localparam int EFF_DEPTH = SB_DEPTH - 1;
`else
  localparam int EFF_DEPTH = SB_DEPTH;
`endif
  localparam int JCW = (JR_PENALTY > 1) ? $clog2(JR_PENALTY) : 1;
  localparam int RLW = $clog2(MAX_STALL + 2);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, JR_FLUSH = 2'd2} state_t;

  state_t                                   state_q;
  logic [JCW-1:0]                           jr_cnt_q;
  logic [SB_DEPTH-1:0]                      sb_vld_q;
  logic [SB_DEPTH-1:0][REG_ADDR_WIDTH-1:0]  sb_dst_q;
  logic [SB_DEPTH-1:0]                      slot_hit;
  logic                                     flush_q;
  logic [RLW-1:0]                           run_len_q, run_len_d;
  logic [CNT_WIDTH-1:0]                     stall_cnt_q, stall_cnt_d;
  logic                                     err_q, err_d;
  logic                                     hz, active, jr_take, stall, redir_take, sb_in_vld;

  // Slots beyond the effective depth retire without being compared.
  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_slot
    if (i < EFF_DEPTH) begin : g_chk
      pipeline_hazard_ctrl_slot #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_slot (
        .vld_i    (sb_vld_q[i]),
        .dst_i    (sb_dst_q[i]),
        .rs_i     (id_rs),
        .rt_i     (id_rt),
        .use_rs_i (id_use_rs),
        .use_rt_i (id_use_rt),
        .hit_o    (slot_hit[i])
      );
    end else begin : g_nochk
      assign slot_hit[i] = 1'b0;
    end
  end

  assign hz         = |slot_hit;
  assign active     = (state_q != JR_FLUSH);
  // jr beats a hazard; a hazard beats a redirect whose branch operands are still stale.
  assign jr_take    = active & ex_jr;
  assign stall      = active & ~ex_jr & hz;
  assign redir_take = active & ~ex_jr & ~hz & id_redirect;

  assign pc_en_n     = stall;
  assign ifid_en_n   = stall;
  assign idex_bubble = stall | jr_take | (state_q == JR_FLUSH);
  assign if_flush    = flush_q | (state_q == JR_FLUSH);
  assign sb_in_vld   = id_regWrite & ~idex_bubble & (id_regToWrite != '0);

  always_comb begin
    run_len_d = '0;
    if (stall) run_len_d = (run_len_q > RLW'(MAX_STALL)) ? run_len_q : run_len_q + RLW'(1);
    err_d       = err_q | (run_len_d > RLW'(MAX_STALL));
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_vld_q <= '0;
      sb_dst_q <= '0;
    end else begin
      sb_vld_q <= {sb_vld_q[SB_DEPTH-2:0], sb_in_vld};
      sb_dst_q <= {sb_dst_q[SB_DEPTH-2:0], id_regToWrite};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      jr_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN, STALL: begin
          if (jr_take) begin
            state_q  <= JR_FLUSH;
            jr_cnt_q <= JCW'(JR_PENALTY - 1);
          end else begin
            state_q  <= stall ? STALL : RUN;
          end
        end
        JR_FLUSH: begin
          if (jr_cnt_q == '0) state_q <= RUN;
          else                jr_cnt_q <= jr_cnt_q - JCW'(1);
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // The first fetch after reset is killed, hence flush_q resets to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q     <= 1'b1;
      run_len_q   <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      flush_q     <= redir_take;
      run_len_q   <= run_len_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a history-based model.
module tb_pipeline_hazard_ctrl;
  localparam int SB = 3, JRP = 2, MAXS = 7, MAXS2 = 1;
`ifdef WB_BYPASS_EN
  localparam int EFF = SB - 1;
`else
  localparam int EFF = SB;
`endif
  localparam int EXP_RAW = EFF;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, id_regToWrite;
  logic id_use_rs, id_use_rt, id_regWrite, id_redirect, ex_jr;
  logic pc_en_n, ifid_en_n, if_flush, idex_bubble, err;
  logic [15:0] stall_cnt;
  logic pc2, ifid2, flush2, bub2, err2;
  logic [1:0] cnt2;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_regWrite(id_regWrite), .id_regToWrite(id_regToWrite), .id_redirect(id_redirect), .ex_jr(ex_jr),
    .pc_en_n(pc_en_n), .ifid_en_n(ifid_en_n), .if_flush(if_flush), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .err(err));

  pipeline_hazard_ctrl #(.MAX_STALL(MAXS2), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_regWrite(id_regWrite), .id_regToWrite(id_regToWrite), .id_redirect(id_redirect), .ex_jr(ex_jr),
    .pc_en_n(pc2), .ifid_en_n(ifid2), .if_flush(flush2), .idex_bubble(bub2),
    .stall_cnt(cnt2), .err(err2));

  always #5 clk = ~clk;

  int vec = 0, bad = 0;

  // Model: hist[k] = destination written k+1 cycles ago (0 = nothing); jr penalty as a plain countdown.
  int  hist[$];
  int  m_jr_left, m_run, m_run2, m_stalls;
  bit  m_flush, m_err, m_err2;
  bit  e_pc, e_bub, e_flush, e_stall, n_flush;
  int  n_write, n_jr;

  function automatic logic [1:0] sat2(input int s);
    return (s > 3) ? 2'd3 : 2'(s);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_flush = 1; m_jr_left = 0; m_run = 0; m_run2 = 0; m_err = 0; m_err2 = 0; m_stalls = 0;
  endtask

  task automatic model_eval();
    bit hz = 0;
    for (int k = 0; k < EFF && k < hist.size(); k++)
      if (hist[k] != 0 && ((id_use_rs && hist[k] == int'(id_rs)) || (id_use_rt && hist[k] == int'(id_rt)))) hz = 1;
    e_flush = m_flush; n_flush = 0; e_stall = 0; n_jr = m_jr_left;
    if (m_jr_left > 0) begin e_pc = 0; e_bub = 1; e_flush = 1; n_jr = m_jr_left - 1; end
    else if (ex_jr)    begin e_pc = 0; e_bub = 1; n_jr = JRP; end
    else if (hz)       begin e_pc = 1; e_bub = 1; e_stall = 1; end
    else               begin e_pc = 0; e_bub = 0; n_flush = id_redirect; end
    n_write = (id_regWrite && !e_bub) ? int'(id_regToWrite) : 0;
  endtask

  task automatic model_commit();
    hist.push_front(n_write);
    if (hist.size() > SB) void'(hist.pop_back());
    m_flush = n_flush; m_jr_left = n_jr;
    m_run  = e_stall ? m_run + 1 : 0;
    m_run2 = e_stall ? m_run2 + 1 : 0;
    if (m_run > MAXS) m_err = 1;
    if (m_run2 > MAXS2) m_err2 = 1;
    if (e_stall) m_stalls++;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_regWrite = 0; id_regToWrite = 0;
    id_redirect = 0; ex_jr = 0;
  endtask

  task automatic drive(input int rs, input int rt, input bit urs, input bit urt, input bit rw,
                       input int dst, input bit rd, input bit jr);
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt; id_regWrite = rw;
    id_regToWrite = 5'(dst); id_redirect = rd; ex_jr = jr;
  endtask

  task automatic cycle_begin(); @(negedge clk); model_eval(); endtask
  task automatic cycle_end();   @(posedge clk); model_commit(); #1; endtask

  task automatic do_reset();
    idle(); rst = 0;
    @(posedge clk); #1 rst = 1;
    model_reset();
  endtask

  task automatic test_reset();
    vec++;
    if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err} !== 5'b00100 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_init got %b cnt=%0d expected 00100 cnt=0", {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt);
    end
    @(posedge clk); #1 rst = 1; model_reset();
    drive(1, 2, 1, 1, 1, 3, 0, 0);
    cycle_begin(); cycle_end();
    drive(3, 0, 1, 0, 1, 4, 0, 0);
    cycle_begin();
    vec++;
    if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err, stall_cnt} !== {e_pc, e_pc, e_flush, e_bub, m_err, 16'(m_stalls)}) begin
      bad++; $display("FAIL reset_pre t=%0t got %b cnt=%0d expected %b cnt=%0d", $time, {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt, {e_pc, e_pc, e_flush, e_bub, m_err}, m_stalls);
    end
    cycle_end();
    vec++;
    if (pc_en_n !== 1'b1) begin bad++; $display("FAIL reset_midstall pc_en_n=%b expected 1", pc_en_n); end
    rst = 0; #1;
    vec++;
    if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err} !== 5'b00100 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_async got %b cnt=%0d expected 00100 cnt=0", {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt);
    end
    @(posedge clk); #1; idle(); rst = 1; model_reset();
  endtask

  task automatic test_raw();
    int nst = 0;
    do_reset();
    drive(1, 2, 1, 1, 1, 3, 0, 0);
    cycle_begin(); cycle_end();
    drive(3, 1, 1, 1, 1, 4, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cycle_begin();
      vec++;
      if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err, stall_cnt} !== {e_pc, e_pc, e_flush, e_bub, m_err, 16'(m_stalls)}) begin
        bad++; $display("FAIL raw t=%0t got %b cnt=%0d expected %b cnt=%0d", $time, {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt, {e_pc, e_pc, e_flush, e_bub, m_err}, m_stalls);
      end
      if (pc_en_n === 1'b1) nst++;
      cycle_end();
      if (!e_pc) break;
    end
    idle();
    vec++;
    if (nst != EXP_RAW || int'(stall_cnt) != EXP_RAW) begin
      bad++; $display("FAIL raw_len stall_cycles=%0d cnt=%0d expected %0d", nst, stall_cnt, EXP_RAW);
    end
  endtask

  task automatic test_zero_unused();
    do_reset();
    drive(1, 2, 1, 1, 1, 0, 0, 0); cycle_begin(); cycle_end();
    drive(0, 0, 1, 1, 0, 0, 0, 0); cycle_begin();
    vec++;
    if (pc_en_n !== 1'b0 || e_pc) begin bad++; $display("FAIL zero_reg pc_en_n=%b model=%b expected 0", pc_en_n, e_pc); end
    cycle_end();
    drive(1, 2, 1, 1, 1, 5, 0, 0); cycle_begin(); cycle_end();
    drive(5, 6, 0, 0, 1, 6, 0, 0); cycle_begin();
    vec++;
    if (pc_en_n !== 1'b0 || idex_bubble !== 1'b0) begin
      bad++; $display("FAIL unused_rs pc_en_n=%b bubble=%b expected 0 0", pc_en_n, idex_bubble);
    end
    cycle_end();
    idle();
  endtask

  task automatic test_branch();
    logic [2:0] fl;
    int first = -1;
    do_reset();
    cycle_begin(); cycle_end();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      vec++;
      if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err, stall_cnt} !== {e_pc, e_pc, e_flush, e_bub, m_err, 16'(m_stalls)}) begin
        bad++; $display("FAIL branch t=%0t got %b cnt=%0d expected %b cnt=%0d", $time, {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt, {e_pc, e_pc, e_flush, e_bub, m_err}, m_stalls);
      end
      fl[2-k] = if_flush;
      cycle_end();
      idle();
    end
    vec++;
    if (fl !== 3'b010) begin bad++; $display("FAIL branch_flush seq=%b expected 010", fl); end
    drive(1, 2, 1, 1, 1, 9, 0, 0); cycle_begin(); cycle_end();
    drive(9, 0, 1, 1, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      cycle_begin();
      vec++;
      if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err, stall_cnt} !== {e_pc, e_pc, e_flush, e_bub, m_err, 16'(m_stalls)}) begin
        bad++; $display("FAIL branch_hz t=%0t got %b cnt=%0d expected %b cnt=%0d", $time, {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt, {e_pc, e_pc, e_flush, e_bub, m_err}, m_stalls);
      end
      if (if_flush === 1'b1 && first < 0) first = k;
      cycle_end();
      if (!e_pc) idle();
    end
    vec++;
    if (first != EXP_RAW + 1) begin bad++; $display("FAIL branch_hz_delay first_flush=%0d expected %0d", first, EXP_RAW + 1); end
  endtask

  task automatic test_jr_vs_stall();
    logic [11:0] seq = '0;
    do_reset();
    drive(1, 2, 1, 1, 1, 6, 0, 0); cycle_begin(); cycle_end();
    drive(6, 0, 1, 0, 1, 7, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle_begin();
      vec++;
      if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err, stall_cnt} !== {e_pc, e_pc, e_flush, e_bub, m_err, 16'(m_stalls)}) begin
        bad++; $display("FAIL jr t=%0t got %b cnt=%0d expected %b cnt=%0d", $time, {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt, {e_pc, e_pc, e_flush, e_bub, m_err}, m_stalls);
      end
      seq = {seq[8:0], pc_en_n, idex_bubble, if_flush};
      cycle_end();
      if (k == 2) idle();
    end
    vec++;
    if (seq !== 12'b010_011_011_000 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL jr_seq pc/bub/flush=%b cnt=%0d expected 010011011000 cnt=0", seq, stall_cnt);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    repeat (2) begin
      drive(1, 2, 1, 1, 1, 7, 0, 0); cycle_begin(); cycle_end();
      drive(7, 7, 1, 1, 1, 8, 0, 0);
      for (int k = 0; k < 6; k++) begin
        cycle_begin();
        vec++;
        if ({err2, cnt2, pc2, err} !== {m_err2, sat2(m_stalls), e_pc, m_err}) begin
          bad++; $display("FAIL watchdog t=%0t got err2/cnt2/pc2/err=%b expected %b", $time, {err2, cnt2, pc2, err}, {m_err2, sat2(m_stalls), e_pc, m_err});
        end
        cycle_end();
        if (!e_pc) break;
      end
      idle();
    end
    vec++;
    if (err2 !== 1'b1 || cnt2 !== 2'd3 || err !== 1'b0) begin
      bad++; $display("FAIL watchdog_end err2=%b cnt2=%0d err=%b expected 1 3 0", err2, cnt2, err);
    end
  endtask

  task automatic test_random();
    do_reset();
    e_pc = 0;
    for (int n = 0; n < 600; n++) begin
      if (!e_pc)
        drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      cycle_begin();
      vec++;
      if ({pc_en_n, ifid_en_n, if_flush, idex_bubble, err, stall_cnt, pc2, ifid2, flush2, bub2, err2, cnt2} !==
          {e_pc, e_pc, e_flush, e_bub, m_err, 16'(m_stalls), e_pc, e_pc, e_flush, e_bub, m_err2, sat2(m_stalls)}) begin
        bad++; $display("FAIL random n=%0d got %b cnt=%0d dut2=%b expected %b cnt=%0d dut2=%b", n,
          {pc_en_n, ifid_en_n, if_flush, idex_bubble, err}, stall_cnt, {pc2, ifid2, flush2, bub2, err2, cnt2},
          {e_pc, e_pc, e_flush, e_bub, m_err}, m_stalls, {e_pc, e_pc, e_flush, e_bub, m_err2, sat2(m_stalls)});
      end
      cycle_end();
    end
    idle();
  endtask

  initial begin
    rst = 1; idle();
    #1 rst = 0;
    #1;
    test_reset();
    test_raw();
    test_zero_unused();
    test_branch();
    test_jr_vs_stall();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
